mcht_tx_queue: RTL and testbench
================================

Name: mcht_tx_queue

Overview:
- Transmit-side message queue and launcher that sits directly upstream of the Manchester transceiver TX path. Inputs are TX_VLD/TX_MSG/TX_DNE at the encoder.
- Buffers pDEPTH messages from the host logic.
- Launches one frame at a time with a single-cycle start pulse and holds the message stable until the encoder reports done.
- Enforces a programmable idle gap between frames.

Parameters:
- pMSG_LEN, 16: message width; must match the encoder's message length.
- pDEPTH, 4: queue depth in entries; a power of 2, at least 2.
- pGAP, 8: idle cycles inserted after TX_DNE before the next launch; 0 means no gap.
- pTMO, 1024: BUSY-state cycles before timeout abort (used only with the optional feature).

Ports:
- CLK_25M  in  1  sole clock, 25 MHz bit clock of the encoder.
- RST  in  1  asynchronous, active-high reset.
- IN_VLD  in  1  host write strobe.
- IN_MSG  in  pMSG_LEN  host message.
- IN_RDY  out  1  queue can accept; high when Q_CNT < pDEPTH.
- TX_VLD  out  1  one-cycle frame-start pulse to the encoder.
- TX_MSG  out  pMSG_LEN  message to the encoder; stable from TX_VLD until the cycle TX_DNE is sampled.
- TX_DNE  in  1  one-cycle frame-done pulse from the encoder.
- Q_CNT  out  $clog2(pDEPTH)+1  current occupancy.
- TMO_ERR  out  1  one-cycle pulse on a frame-done timeout.

Behaviour:
- Reset values: IN_RDY=1, TX_VLD=0, TX_MSG=0, Q_CNT=0, TMO_ERR=0, FSM=IDLE, queue empty.
- Reset is asynchronous and may arrive mid-frame. It flushes the queue and drops TX_VLD immediately; the frame in flight is abandoned.
- Push: an entry is written on a CLK_25M edge when IN_VLD && IN_RDY. IN_VLD while full is ignored and the data is lost; the host must check IN_RDY.
- There is no full-bypass: IN_RDY is derived from registered occupancy only, so a simultaneous pop does not make room in the same cycle.
- Pop: occurs on the IDLE->LAUNCH transition.
- Simultaneous push and pop leaves Q_CNT unchanged. Read/write pointers wrap modulo pDEPTH.
- FSM states: IDLE, LAUNCH, BUSY, GAP.
  - IDLE: if Q_CNT>0, go to LAUNCH; load TX_MSG with the head entry and pop it.
  - LAUNCH: TX_VLD=1 for exactly this cycle; unconditionally go to BUSY.
  - BUSY: on TX_DNE, go to GAP if pGAP>0, else IDLE. The gap counter loads pGAP-1 on entry.
  - GAP: decrement the counter each cycle; at 0, go to IDLE.
- Latency: a message pushed into an empty idle queue at edge k gives TX_VLD high in the cycle following edge k+1.
- Back-to-back frame spacing: TX_DNE cycle, then pGAP GAP cycles, 1 IDLE cycle, then LAUNCH.
- TX_DNE outside BUSY is ignored, including a TX_DNE coincident with LAUNCH.
- TX_MSG is held after the frame until the next launch.
- Pushing during LAUNCH, BUSY or GAP is allowed and does not disturb TX_MSG.

Optional Feature:
- Macro: MCHT_TXQ_TIMEOUT_EN.
- When defined:
  - A BUSY cycle counter clears on BUSY entry.
  - If it reaches pTMO-1 without TX_DNE, TMO_ERR pulses for 1 cycle and the FSM goes to GAP. The frame is dropped and the next entry is sent normally.
  - TX_DNE arriving in the same cycle as the timeout takes priority, so there is no TMO_ERR.
- When undefined: BUSY waits indefinitely, TMO_ERR is tied to 0, and no timeout counter is synthesized.

Decomposition:
- Package mcht_pkg holds the state enum (IDLE, LAUNCH, BUSY, GAP) and localparam helpers for pointer and count widths.
- One natural sub-module: mcht_sync_fifo (parameters width and depth; push/pop, data out, count). It is instantiated once, and the launcher FSM stays in mcht_tx_queue.

Test Plan:
- Single frame: push 16'hA5C3 into an empty queue at edge k -> TX_VLD one-cycle pulse after edge k+1 with TX_MSG=16'hA5C3; Q_CNT goes 1->0; TX_MSG holds until TX_DNE.
- Fill and backpressure: push 5 messages back-to-back with the encoder stalled (no TX_DNE), pDEPTH=4 -> first enters launch, next 4 fill the queue, IN_RDY=0 with Q_CNT=4. A 6th push is dropped. After each TX_DNE, frames launch in order with exactly pGAP=8 GAP cycles plus 1 IDLE cycle between TX_DNE and the next TX_VLD.
- Simultaneous push/pop: push on the exact IDLE->LAUNCH cycle with Q_CNT=2 -> Q_CNT stays 2; order is preserved across pointer wrap (more than 8 messages streamed).
- Spurious TX_DNE: pulse TX_DNE in IDLE and in GAP -> no state change, no launch, no queue change.
- Reset mid-frame: assert RST asynchronously while in BUSY with Q_CNT=3 -> TX_VLD=0, Q_CNT=0, IN_RDY=1 immediately. After release, a new push launches normally.
- Timeout (MCHT_TXQ_TIMEOUT_EN, pTMO=16): launch and withhold TX_DNE -> TMO_ERR pulses for one cycle in BUSY cycle 16, then GAP, then the next queued frame launches. Without the macro: no TMO_ERR and BUSY persists.

Source files
------------

// File: rtl/mcht_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcht_pkg
//  Description : Shared launcher state encoding and pointer/count width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcht_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        GAP    = 2'd3
    } state_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy needs one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcht_tx_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : mcht_tx_queue_if
//  Description : Host-write and encoder-launch signal bundle of the TX queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mcht_tx_queue_if
    import mcht_pkg::*;
#(
    parameter int pMSG_LEN = 16,
    parameter int pDEPTH   = 4
);
    logic                         IN_VLD;
    logic [pMSG_LEN-1:0]          IN_MSG;
    logic                         IN_RDY;
    logic                         TX_VLD;
    logic [pMSG_LEN-1:0]          TX_MSG;
    logic                         TX_DNE;
    logic [cnt_w(pDEPTH)-1:0]     Q_CNT;
    logic                         TMO_ERR;

    modport master (
        output IN_VLD, IN_MSG, TX_DNE,
        input  IN_RDY, TX_VLD, TX_MSG, Q_CNT, TMO_ERR
    );

    modport slave (
        input  IN_VLD, IN_MSG, TX_DNE,
        output IN_RDY, TX_VLD, TX_MSG, Q_CNT, TMO_ERR
    );
endinterface
`default_nettype wire

// File: rtl/mcht_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mcht_sync_fifo
//  Description : Single-clock FIFO with show-ahead head data and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcht_sync_fifo
    import mcht_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_push,
    input  wire logic [WIDTH-1:0]          i_data,
    input  wire logic                      i_pop,
    output logic      [WIDTH-1:0]          o_data,
    output logic      [cnt_w(DEPTH)-1:0]   o_count
);
    localparam int c_PW = ptr_w(DEPTH);
    localparam int c_CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    assign w_do_push = i_push && (r_count != c_CW'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mcht_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mcht_tx_queue
//  Description : TX message queue and frame launcher ahead of the Manchester
//                encoder; enforces an idle gap between frames.
//                Optional busy timeout enabled by MCHT_TXQ_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcht_tx_queue
    import mcht_pkg::*;
#(
    parameter int pMSG_LEN = 16,
    parameter int pDEPTH   = 4,
    parameter int pGAP     = 8,
    parameter int pTMO     = 1024
) (
    input  wire logic      CLK_25M,
    input  wire logic      RST,
    mcht_tx_queue_if.slave bus
);
    localparam int              c_CW     = cnt_w(pDEPTH);
    localparam int              c_GW     = (pGAP > 1) ? $clog2(pGAP) : 1;
    localparam logic [c_GW-1:0] c_GAP_LD = c_GW'((pGAP > 0) ? pGAP - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_GW-1:0]     r_gap_cnt;
    logic [pMSG_LEN-1:0] r_tx_msg;
    logic [pMSG_LEN-1:0] w_head;
    logic [c_CW-1:0]     w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_tmo;

    // Ready comes from registered occupancy only: a same-cycle pop frees no slot.
    assign w_push = bus.IN_VLD && bus.IN_RDY;

    mcht_sync_fifo #(
        .WIDTH (pMSG_LEN),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .clk     (CLK_25M),
        .rst     (RST),
        .i_push  (w_push),
        .i_data  (bus.IN_MSG),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count)
    );

`ifdef MCHT_TXQ_TIMEOUT_EN
    localparam int c_TW = (pTMO > 1) ? $clog2(pTMO) : 1;

    logic [c_TW-1:0] r_tmo_cnt;

    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST)                    r_tmo_cnt <= '0;
        else if (r_state == LAUNCH) r_tmo_cnt <= '0;
        else if (r_state == BUSY)   r_tmo_cnt <= r_tmo_cnt + c_TW'(1);
    end

    // A done pulse in the expiry cycle wins, so no error is flagged then.
    assign w_tmo = (r_state == BUSY) && !bus.TX_DNE && (r_tmo_cnt == c_TW'(pTMO - 1));
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count != '0) begin
                    w_state_nxt = LAUNCH;
                    w_pop       = 1'b1;
                end
            end
            LAUNCH:  w_state_nxt = BUSY;
            BUSY: begin
                if (bus.TX_DNE || w_tmo) w_state_nxt = (pGAP > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (r_gap_cnt == '0) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_25M or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
            r_tx_msg  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_tx_msg <= w_head;
            if (r_state == BUSY && w_state_nxt == GAP)
                r_gap_cnt <= c_GAP_LD;
            else if (r_state == GAP && r_gap_cnt != '0)
                r_gap_cnt <= r_gap_cnt - c_GW'(1);
        end
    end

    assign bus.IN_RDY  = (w_count != c_CW'(pDEPTH));
    assign bus.TX_VLD  = (r_state == LAUNCH);
    assign bus.TX_MSG  = r_tx_msg;
    assign bus.Q_CNT   = w_count;
    assign bus.TMO_ERR = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mcht_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcht_tx_queue
//  Description : Directed self-checking bench for the TX queue/launcher.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcht_tx_queue;
    import mcht_pkg::*;

    localparam int c_GAP    = 8;
    localparam int c_TMO    = 16;
    localparam int c_SPACE  = c_GAP + 2;   // negedges from the done-drop to the next launch
    localparam int c_STREAM = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    mcht_tx_queue_if #(.pMSG_LEN(16), .pDEPTH(4)) bus ();

    mcht_tx_queue #(
        .pMSG_LEN (16),
        .pDEPTH   (4),
        .pGAP     (c_GAP),
        .pTMO     (c_TMO)
    ) dut (
        .CLK_25M (clk),
        .RST     (rst),
        .bus     (bus)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle done pulse; returns at the first negedge after it was sampled.
    task automatic dne();
        bus.TX_DNE = 1'b1;
        @(negedge clk);
        bus.TX_DNE = 1'b0;
    endtask

    task automatic wait_vld(inout int n);
        while (!bus.TX_VLD && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [15:0] fill [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    logic [15:0] exp_q [$];

    initial begin
        int n;
        int busy;
        int tx_idx;
        int rx;
        logic seen;

        bus.IN_VLD = 1'b0;
        bus.IN_MSG = '0;
        bus.TX_DNE = 1'b0;
        cyc(2);
        chk("rst_in_rdy",  bus.IN_RDY,  1);
        chk("rst_tx_vld",  bus.TX_VLD,  0);
        chk("rst_tx_msg",  bus.TX_MSG,  0);
        chk("rst_q_cnt",   bus.Q_CNT,   0);
        chk("rst_tmo_err", bus.TMO_ERR, 0);
        rst = 1'b0;
        cyc(1);

        // Single frame: launch one cycle after the push has landed
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'hA5C3;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        chk("single_q1",    bus.Q_CNT,  1);
        chk("single_novld", bus.TX_VLD, 0);
        @(negedge clk);
        chk("single_vld",   bus.TX_VLD, 1);
        chk("single_msg",   bus.TX_MSG, 16'hA5C3);
        chk("single_q0",    bus.Q_CNT,  0);
        @(negedge clk);
        chk("single_pulse", bus.TX_VLD, 0);
        cyc(5);
        chk("single_hold",  bus.TX_MSG, 16'hA5C3);
        dne();
        chk("single_after", bus.TX_MSG, 16'hA5C3);
        cyc(12);

        // Fill and backpressure: first entry launches, next four fill the queue
        for (int i = 0; i < 5; i++) begin
            bus.IN_VLD = 1'b1; bus.IN_MSG = fill[i];
            @(negedge clk);
        end
        chk("fill_q4",   bus.Q_CNT,  4);
        chk("fill_rdy0", bus.IN_RDY, 0);
        chk("fill_msg0", bus.TX_MSG, fill[0]);
        bus.IN_MSG = 16'hDEAD;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        chk("fill_drop", bus.Q_CNT, 4);
        for (int k = 1; k < 4; k++) begin
            dne();
            n = 1;
            wait_vld(n);
            chk("fill_space", n, c_SPACE);
            chk("fill_order", bus.TX_MSG, fill[k]);
            chk("fill_qcnt",  bus.Q_CNT, 4 - k);
            @(negedge clk);
        end

        // Push exactly on the IDLE->LAUNCH edge with two entries queued
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'h00AA;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        dne();
        cyc(c_GAP);
        chk("simul_idle_q", bus.Q_CNT, 2);
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'h00CC;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        chk("simul_vld", bus.TX_VLD, 1);
        chk("simul_msg", bus.TX_MSG, fill[4]);
        chk("simul_q2",  bus.Q_CNT,  2);

        // Stream through several pointer wraps with an encoder answering after 3 cycles
        exp_q.push_back(16'h00AA);
        exp_q.push_back(16'h00CC);
        @(negedge clk);
        busy = 2; tx_idx = 0; rx = 0;
        for (int c = 0; c < 1000 && rx < c_STREAM + 2; c++) begin
            bus.TX_DNE = 1'b0;
            if (bus.TX_VLD) begin
                if (exp_q.size() == 0) chk("stream_extra", 1, 0);
                else chk("stream_msg", bus.TX_MSG, exp_q.pop_front());
                rx++;
                busy = 3;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) bus.TX_DNE = 1'b1;
            end
            if (tx_idx < c_STREAM && bus.IN_RDY) begin
                bus.IN_VLD = 1'b1;
                bus.IN_MSG = 16'h3C00 + 16'(tx_idx) * 16'h0101;
                exp_q.push_back(bus.IN_MSG);
                tx_idx++;
            end else begin
                bus.IN_VLD = 1'b0;
            end
            @(negedge clk);
        end
        bus.IN_VLD = 1'b0;
        bus.TX_DNE = 1'b0;
        chk("stream_count", rx, c_STREAM + 2);
        chk("stream_empty", exp_q.size(), 0);
        dne();
        cyc(12);

        // Spurious done in IDLE, at LAUNCH and in GAP
        dne();
        cyc(2);
        chk("spur_idle_q",   bus.Q_CNT,  0);
        chk("spur_idle_vld", bus.TX_VLD, 0);
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'h0F0F;
        @(negedge clk);
        bus.IN_MSG = 16'hF0F0;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        chk("spur_launch_vld", bus.TX_VLD, 1);
        chk("spur_launch_msg", bus.TX_MSG, 16'h0F0F);
        dne();
        cyc(12);
        chk("spur_launch_busy", bus.Q_CNT,  1);
        chk("spur_launch_hold", bus.TX_MSG, 16'h0F0F);
        dne();
        cyc(2);
        dne();
        n = 4;
        wait_vld(n);
        chk("spur_gap_space", n, c_SPACE);
        chk("spur_gap_msg",   bus.TX_MSG, 16'hF0F0);

        // Asynchronous reset in BUSY with three entries queued
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.IN_VLD = 1'b1; bus.IN_MSG = 16'h7700 + 16'(i);
            @(negedge clk);
        end
        bus.IN_VLD = 1'b0;
        chk("arst_pre_q", bus.Q_CNT, 3);
        #5 rst = 1'b1;
        #1;
        chk("arst_vld", bus.TX_VLD, 0);
        chk("arst_q",   bus.Q_CNT,  0);
        chk("arst_rdy", bus.IN_RDY, 1);
        chk("arst_msg", bus.TX_MSG, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'h1234;
        @(negedge clk);
        bus.IN_VLD = 1'b0;
        @(negedge clk);
        chk("arst_relaunch_vld", bus.TX_VLD, 1);
        chk("arst_relaunch_msg", bus.TX_MSG, 16'h1234);

`ifdef MCHT_TXQ_TIMEOUT_EN
        // Withheld done: error pulse in BUSY cycle pTMO, then the gap and next frame
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'hCAFE;
        seen = 1'b0;
        for (int i = 1; i <= c_TMO; i++) begin
            @(negedge clk);
            bus.IN_VLD = 1'b0;
            if (i < c_TMO && bus.TMO_ERR) seen = 1'b1;
        end
        chk("tmo_early", seen, 0);
        chk("tmo_pulse", bus.TMO_ERR, 1);
        @(negedge clk);
        chk("tmo_single", bus.TMO_ERR, 0);
        n = 1;
        wait_vld(n);
        chk("tmo_next_space", n, c_SPACE);
        chk("tmo_next_msg",   bus.TX_MSG, 16'hCAFE);
        cyc(c_TMO);
        bus.TX_DNE = 1'b1;
        #1;
        chk("tmo_dne_prio", bus.TMO_ERR, 0);
        @(negedge clk);
        bus.TX_DNE = 1'b0;
        chk("tmo_dne_after", bus.TMO_ERR, 0);
`else
        // Without the timeout, BUSY persists and no error is ever flagged
        bus.IN_VLD = 1'b1; bus.IN_MSG = 16'hCAFE;
        seen = 1'b0;
        for (int i = 0; i < 3 * c_TMO; i++) begin
            @(negedge clk);
            bus.IN_VLD = 1'b0;
            if (bus.TMO_ERR || bus.TX_VLD) seen = 1'b1;
        end
        chk("notmo_err",  seen, 0);
        chk("notmo_busy", bus.Q_CNT, 1);
        chk("notmo_msg",  bus.TX_MSG, 16'h1234);
        dne();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
